// File: rtl/commit_trace_pkg.sv
// Shared types for the commit tracer: record payload, header bit positions, serializer states.
// Optional COMMIT_TRACE_CYCLE_EN adds a per-record cycle stamp word after inst.
package commit_trace_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RA_W        = 5;
    localparam int unsigned SEQ_W       = 24;
    localparam int unsigned HDR_HALT    = 31;
    localparam int unsigned HDR_REG_WE  = 30;
    localparam int unsigned HDR_DMEM_WE = 29;
    localparam int unsigned HDR_WA_LSB  = 24;
    localparam int unsigned HDR_CYC     = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    typedef enum logic [2:0] {
        W_HDR  = 3'd0,
        W_PC   = 3'd1,
        W_INST = 3'd2,
        W_CYC  = 3'd3,
        W_RWD  = 3'd4,
        W_DWA  = 3'd5,
        W_DWD  = 3'd6
    } word_t;

    typedef struct packed {
        logic             halt;
        logic             reg_we;
        logic             dmem_we;
        logic [RA_W-1:0]  reg_wa;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  reg_wd;
        logic [XLEN-1:0]  dmem_wa;
        logic [XLEN-1:0]  dmem_wd;
`ifdef COMMIT_TRACE_CYCLE_EN
        logic [XLEN-1:0]  cycle;
`endif
        logic [SEQ_W-1:0] seq;
    } commit_rec_t;

    // Word that follows the fixed pc/inst(/cycle) part of a record; W_HDR marks end of record.
    function automatic word_t tail_word(commit_rec_t r);
        if (r.reg_we)       return W_RWD;
        else if (r.dmem_we) return W_DWA;
        else                return W_HDR;
    endfunction

    function automatic word_t next_word(commit_rec_t r, word_t w);
        word_t n;
        case (w)
            W_HDR:   n = W_PC;
`ifdef COMMIT_TRACE_CYCLE_EN
            W_INST:  n = W_CYC;
`else
            W_INST:  n = tail_word(r);
`endif
            W_PC:    n = W_INST;
            W_CYC:   n = tail_word(r);
            W_RWD:   n = r.dmem_we ? W_DWA : W_HDR;
            W_DWA:   n = W_DWD;
            default: n = W_HDR;
        endcase
        return n;
    endfunction

    function automatic logic [XLEN-1:0] header(commit_rec_t r);
        logic [XLEN-1:0] h;
        h = {r.halt, r.reg_we, r.dmem_we, r.reg_wa, r.seq};
`ifdef COMMIT_TRACE_CYCLE_EN
        h[HDR_CYC] = 1'b1;
`endif
        return h;
    endfunction

    function automatic logic [XLEN-1:0] word_data(commit_rec_t r, word_t w);
        logic [XLEN-1:0] d;
        case (w)
            W_HDR:   d = header(r);
            W_PC:    d = r.pc;
            W_INST:  d = r.inst;
`ifdef COMMIT_TRACE_CYCLE_EN
            W_CYC:   d = r.cycle;
`endif
            W_RWD:   d = r.reg_wd;
            W_DWA:   d = r.dmem_wa;
            W_DWD:   d = r.dmem_wd;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Record FIFO for the commit tracer; DEPTH must be a power of two so pointers wrap naturally.
// A push on a full FIFO is taken when a pop happens in the same cycle.
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  commit_rec_t                    wdata,
    output commit_rec_t                    head_c,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    commit_rec_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] count_d;

    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign count_d = count + CNT_W'(wr_en) - CNT_W'(rd_en);
    assign head_c  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/commit_tracer.sv
// Captures CPU commit records into a FIFO and serializes them as a valid/ready word stream.
// Define COMMIT_TRACE_CYCLE_EN to stamp each record with a free-running cycle count.
module commit_tracer
    import commit_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit,
    input  logic [XLEN-1:0]      commit_pc,
    input  logic [XLEN-1:0]      commit_inst,
    input  logic                 commit_halt,
    input  logic                 commit_reg_we,
    input  logic                 commit_dmem_we,
    input  logic [RA_W-1:0]      commit_reg_wa,
    input  logic [XLEN-1:0]      commit_reg_wd,
    input  logic [XLEN-1:0]      commit_dmem_wa,
    input  logic [XLEN-1:0]      commit_dmem_wd,
    output logic                 hold,
    output logic                 trace_valid,
    output logic [XLEN-1:0]      trace_data,
    input  logic                 trace_ready,
    output logic                 overflow,
    output logic [15:0]          drop_cnt,
    output logic [XLEN-1:0]      instret,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ser_state_t       state, state_d;
    word_t            word, word_d, nxt_c;
    commit_rec_t      cur, cur_d, rec_c, head_c;
    logic             pop_c, push_c, drop_c;
    logic             full, empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occ_next;
    logic             valid_d, done_d;
    logic [XLEN-1:0]  data_d;
    logic             halt_seen;
`ifdef COMMIT_TRACE_CYCLE_EN
    logic [XLEN-1:0]  cycle_cnt;
`endif

    always_comb begin
        rec_c         = '0;
        rec_c.halt    = commit_halt;
        rec_c.reg_we  = commit_reg_we;
        rec_c.dmem_we = commit_dmem_we;
        rec_c.reg_wa  = commit_reg_wa;
        rec_c.pc      = commit_pc;
        rec_c.inst    = commit_inst;
        rec_c.reg_wd  = commit_reg_wd;
        rec_c.dmem_wa = commit_dmem_wa;
        rec_c.dmem_wd = commit_dmem_wd;
        rec_c.seq     = instret[SEQ_W-1:0];
`ifdef COMMIT_TRACE_CYCLE_EN
        rec_c.cycle   = cycle_cnt;
`endif
    end

    // Once a halt record is in, later commits are neither accepted nor counted as drops.
    assign push_c   = commit && !halt_seen && (!full || pop_c);
    assign drop_c   = commit && !halt_seen && full && !pop_c;
    assign occ_next = {1'b0, count} + (CNT_W + 1)'(push_c) - (CNT_W + 1)'(pop_c);

    commit_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_c),
        .pop    (pop_c),
        .wdata  (rec_c),
        .head_c (head_c),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign nxt_c = next_word(cur, word);

    always_comb begin
        state_d = state;
        word_d  = word;
        cur_d   = cur;
        pop_c   = 1'b0;
        valid_d = 1'b0;
        data_d  = trace_data;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop_c   = 1'b1;
                    cur_d   = head_c;
                    word_d  = W_HDR;
                    valid_d = 1'b1;
                    data_d  = word_data(head_c, W_HDR);
                    state_d = SEND;
                end
            end
            SEND: begin
                valid_d = 1'b1;
                if (trace_ready) begin
                    if (nxt_c != W_HDR) begin
                        word_d = nxt_c;
                        data_d = word_data(cur, nxt_c);
                    end else if (cur.halt) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (!empty) begin
                        // Next record's header follows the last word with no bubble.
                        pop_c  = 1'b1;
                        cur_d  = head_c;
                        word_d = W_HDR;
                        data_d = word_data(head_c, W_HDR);
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            word        <= W_HDR;
            cur         <= '0;
            trace_valid <= 1'b0;
            trace_data  <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            word        <= word_d;
            cur         <= cur_d;
            trace_valid <= valid_d;
            trace_data  <= data_d;
            done        <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instret   <= '0;
            halt_seen <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            hold      <= 1'b0;
        end else begin
            if (push_c) begin
                instret <= instret + XLEN'(1);
                if (commit_halt) halt_seen <= 1'b1;
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            hold <= (occ_next >= (CNT_W + 1)'(DEPTH - 1));
        end
    end

`ifdef COMMIT_TRACE_CYCLE_EN
    always_ff @(posedge clk) begin
        if (!rst) cycle_cnt <= '0;
        else      cycle_cnt <= cycle_cnt + XLEN'(1);
    end
`endif

endmodule

// File: tb/tb_commit_tracer.sv
// Self-checking bench for commit_tracer: directed scenarios plus randomized traffic checked
// against a record-level model that expands each accepted commit into its expected words.
module tb_commit_tracer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit = 1'b0;
    logic [31:0] commit_pc = '0, commit_inst = '0;
    logic        commit_halt = 1'b0, commit_reg_we = 1'b0, commit_dmem_we = 1'b0;
    logic [4:0]  commit_reg_wa = '0;
    logic [31:0] commit_reg_wd = '0, commit_dmem_wa = '0, commit_dmem_wd = '0;
    logic        hold, trace_valid, trace_ready = 1'b0, overflow, done;
    logic [31:0] trace_data, instret;
    logic [15:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int unsigned m_instret = 0;
    bit          m_halted  = 1'b0;

    always #5 clk = ~clk;

    commit_tracer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit         (commit),
        .commit_pc      (commit_pc),
        .commit_inst    (commit_inst),
        .commit_halt    (commit_halt),
        .commit_reg_we  (commit_reg_we),
        .commit_dmem_we (commit_dmem_we),
        .commit_reg_wa  (commit_reg_wa),
        .commit_reg_wd  (commit_reg_wd),
        .commit_dmem_wa (commit_dmem_wa),
        .commit_dmem_wd (commit_dmem_wd),
        .hold           (hold),
        .trace_valid    (trace_valid),
        .trace_data     (trace_data),
        .trace_ready    (trace_ready),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .instret        (instret),
        .done           (done)
    );

    // Inputs change at posedge+1, so a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst && trace_valid && trace_ready) got_q.push_back(trace_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: an accepted commit becomes header, pc, inst, [reg_wd], [dmem_wa, dmem_wd].
    task automatic model_commit(input logic [31:0] pc, inst, input logic halt, rwe, dwe,
                                input logic [4:0] wa, input logic [31:0] wd, dwa, dwd);
        logic [31:0] seq;
        if (m_halted) return;
        seq = m_instret;
        exp_q.push_back({halt, rwe, dwe, wa, seq[23:0]});
        exp_q.push_back(pc);
        exp_q.push_back(inst);
        if (rwe) exp_q.push_back(wd);
        if (dwe) begin
            exp_q.push_back(dwa);
            exp_q.push_back(dwd);
        end
        m_instret++;
        if (halt) m_halted = 1'b1;
    endtask

    task automatic do_commit(input logic [31:0] pc, inst, input logic halt, rwe, dwe,
                             input logic [4:0] wa, input logic [31:0] wd, dwa, dwd,
                             input bit modeled);
        commit = 1'b1;
        commit_pc = pc; commit_inst = inst; commit_halt = halt;
        commit_reg_we = rwe; commit_dmem_we = dwe; commit_reg_wa = wa;
        commit_reg_wd = wd; commit_dmem_wa = dwa; commit_dmem_wd = dwd;
        if (modeled) model_commit(pc, inst, halt, rwe, dwe, wa, wd, dwa, dwd);
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    task automatic rand_commit(input logic halt, input bit modeled);
        do_commit($urandom, $urandom, halt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, $urandom, $urandom, modeled);
    endtask

    task automatic do_reset();
        commit = 1'b0;
        trace_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        m_instret = 0;
        m_halted = 1'b0;
    endtask

    task automatic drain(input int budget, output bit to);
        int n = 0;
        while ((got_q.size() < exp_q.size() || trace_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        to = (got_q.size() < exp_q.size() || trace_valid);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        commit = 1'b0; trace_ready = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", trace_valid); end
        n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL rst_instret got %0d exp 0", instret); end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) rand_commit(1'b0, 1'b0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL dirty_overflow got %b exp 1", overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold got %b exp 0", hold); end
        n_tests++; if (trace_valid !== 1'b0 || trace_data !== 32'd0) begin n_fail++; $display("FAIL rst_trace got v=%b d=%h exp v=0 d=0", trace_valid, trace_data); end
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop got ovf=%b cnt=%0d exp 0 0", overflow, drop_cnt); end
        n_tests++; if (done !== 1'b0 || instret !== 32'd0) begin n_fail++; $display("FAIL rst_done got done=%b instret=%0d exp 0 0", done, instret); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] ref_w [4];
        bit to;
        ref_w[0] = 32'h4100_0000; ref_w[1] = 32'h0; ref_w[2] = 32'h0010_0093; ref_w[3] = 32'h1;
        do_reset();
        trace_ready = 1'b1;
        do_commit(32'h0, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd0, 32'd0, 1'b1);
        drain(50, to);
        n_tests++; if (to || got_q.size() !== 4) begin n_fail++; $display("FAIL single_len got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== ref_w[i]) begin n_fail++; $display("FAIL single_word%0d got %h exp %h", i, got_q[i], ref_w[i]); end
        end
        n_tests++; if (instret !== 32'd1) begin n_fail++; $display("FAIL single_instret got %0d exp 1", instret); end
    endtask

    task automatic test_store();
        logic [31:0] ref_w [5];
        bit to;
        int base;
        ref_w[0] = 32'h2000_0005; ref_w[1] = 32'h0000_0200; ref_w[2] = 32'h00A1_2023;
        ref_w[3] = 32'h0000_1C00; ref_w[4] = 32'h0000_DEAD;
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) rand_commit(1'b0, 1'b1);
        do_commit(32'h200, 32'h00A1_2023, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h1C00, 32'hDEAD, 1'b1);
        drain(200, to);
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL store_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL store_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        base = got_q.size() - 5;
        for (int i = 0; i < 5 && base >= 0; i++) begin
            n_tests++; if (got_q[base + i] !== ref_w[i]) begin n_fail++; $display("FAIL store_word%0d got %h exp %h", i, got_q[base + i], ref_w[i]); end
        end
    endtask

    task automatic test_overflow();
        bit to;
        do_reset();
        trace_ready = 1'b0;
        rand_commit(1'b0, 1'b1);
        @(posedge clk); #1;
        n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_stalled got %b exp 1", trace_valid); end
        for (int k = 1; k <= 9; k++) begin
            rand_commit(1'b0, k <= DEPTH);
            n_tests++; if (hold !== (k >= 7)) begin n_fail++; $display("FAIL ovf_hold%0d got %b exp %b", k, hold, k >= 7); end
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        n_tests++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_dropcnt got %0d exp 1", drop_cnt); end
        n_tests++; if (instret !== 32'd9) begin n_fail++; $display("FAIL ovf_instret got %0d exp 9", instret); end
        trace_ready = 1'b1;
        drain(400, to);
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (hold !== 1'b0) begin n_fail++; $display("FAIL ovf_hold_release got %b exp 0", hold); end
    endtask

    task automatic test_ready_toggle();
        bit          pv = 1'b0;
        logic [31:0] pd = '0;
        int          n = 0;
        bit          to;
        do_reset();
        for (int i = 0; i < 3; i++) rand_commit(1'b0, 1'b1);
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            if (pv) begin
                n_tests++;
                if (trace_valid !== 1'b1 || trace_data !== pd) begin
                    n_fail++; $display("FAIL toggle_stable got v=%b d=%h exp v=1 d=%h", trace_valid, trace_data, pd);
                end
            end
            pv = trace_valid && !trace_ready;
            pd = trace_data;
            @(posedge clk); #1;
            trace_ready = ~trace_ready;
            n++;
        end
        trace_ready = 1'b1;
        drain(50, to);
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL toggle_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        bit to;
        do_reset();
        for (int i = 0; i < 3; i++) rand_commit(1'b0, 1'b1);
        @(posedge clk); #1;
        trace_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 100) begin
            @(negedge clk);
            n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble at word %0d got v=%b exp 1", got_q.size(), trace_valid); end
            @(posedge clk); #1;
            n++;
        end
        drain(20, to);
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_halt();
        bit to;
        do_reset();
        trace_ready = 1'b1;
        rand_commit(1'b0, 1'b1);
        rand_commit(1'b1, 1'b1);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL halt_early_done got %b exp 0", done); end
        rand_commit(1'b0, 1'b1);
        rand_commit(1'b0, 1'b1);
        drain(100, to);
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL halt_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL halt_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (done !== 1'b1 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL halt_done got done=%b v=%b exp 1 0", done, trace_valid); end
        n_tests++; if (instret !== 32'd2) begin n_fail++; $display("FAIL halt_instret got %0d exp 2", instret); end
        n_tests++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL halt_drops got cnt=%0d ovf=%b exp 0 0", drop_cnt, overflow); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        bit to;
        logic [31:0] w;
        do_reset();
        trace_ready = 1'b1;
        do_commit($urandom, $urandom, 1'b0, 1'b1, 1'b1, 5'($urandom), $urandom, $urandom, $urandom, 1'b1);
        while (got_q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (trace_valid !== 1'b0 || trace_data !== 32'd0) begin n_fail++; $display("FAIL midrst_valid got v=%b d=%h exp 0 0", trace_valid, trace_data); end
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL midrst_abandon got %0d words exp 2", got_q.size()); end
        got_q.delete(); exp_q.delete(); m_instret = 0; m_halted = 1'b0;
        rand_commit(1'b0, 1'b1);
        drain(50, to);
        w = (got_q.size() > 0) ? got_q[0] : 32'hFFFF_FFFF;
        n_tests++; if (w[23:0] !== 24'd0) begin n_fail++; $display("FAIL midrst_seq got %0d exp 0", w[23:0]); end
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midrst_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit to;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            trace_ready = 1'($urandom_range(0, 1));
            if (!hold && $urandom_range(0, 1) == 1) rand_commit(1'b0, 1'b1);
            else begin @(posedge clk); #1; end
        end
        trace_ready = 1'b1;
        drain(1000, to);
        n_tests++; if (to || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_stream%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (instret !== m_instret) begin n_fail++; $display("FAIL rand_instret got %0d exp %0d", instret, m_instret); end
        n_tests++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rand_drops got cnt=%0d ovf=%b exp 0 0", drop_cnt, overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_store();
        test_overflow();
        test_ready_toggle();
        test_back_to_back();
        test_halt();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_tracer.md
COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 Parameter DEPTH, default 8, the record FIFO depth in entries; it SHALL be a power of two and at least 4.
REQ-002 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low; the block SHALL reset while rst==0 at a rising clk edge.
REQ-004 commit  input  1  commit strobe from the CPU, sampled when high.
REQ-005 commit_pc, commit_inst  input  32 each  committed PC and instruction.
REQ-006 commit_halt, commit_reg_we, commit_dmem_we  input  1 each  halt, register-write and memory-write flags.
REQ-007 commit_reg_wa  input  5  destination register; commit_reg_wd  input  32  write data.
REQ-008 commit_dmem_wa, commit_dmem_wd  input  32 each  memory write address and data.
REQ-009 hold  output  1  backpressure to the global_en generator; high means the CPU must not commit next cycle.
REQ-010 trace_valid  output  1, trace_data  output  32, trace_ready  input  1  serialized trace word stream.
REQ-011 overflow  output  1  sticky drop indicator; drop_cnt  output  16  count of dropped records.
REQ-012 instret  output  32  count of accepted records; done  output  1  halt record fully drained.

Function
REQ-013 Capture: a record SHALL be accepted in the cycle where commit==1, the FIFO is not full and the halt latch is clear.
REQ-014 A commit arriving while the FIFO is full SHALL be dropped, SHALL set overflow, and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-015 hold SHALL be a registered output that is 1 when the FIFO occupancy after this cycle's push and pop is at least DEPTH-1.
REQ-016 instret SHALL increment by 1 per accepted record and wrap modulo 2^32.
REQ-017 A record's word order SHALL be: header, pc, inst, then reg_wd only if reg_we, then dmem_wa followed by dmem_wd only if dmem_we.
REQ-018 Header layout: [31]=halt, [30]=reg_we, [29]=dmem_we, [28:24]=reg_wa, [23:0]=the low 24 bits of the sequence number.
REQ-019 The sequence number SHALL start at 0 and equal instret at the moment of capture.
REQ-020 Serializer FSM states SHALL be IDLE, SEND and DONE.
REQ-021 IDLE to SEND: the FSM SHALL pop the FIFO head when the FIFO is non-empty; the first word becomes valid one cycle later.
REQ-022 In SEND, trace_valid SHALL be 1, and trace_data SHALL be held stable until the cycle where trace_valid and trace_ready are both 1.
REQ-023 On the last word of a record, SEND SHALL go to IDLE, or back-to-back to the next record if the FIFO is non-empty (no bubble), or to DONE if the record had halt=1.
REQ-024 Halt latch: once a halt record is accepted, all further commits SHALL be ignored; they SHALL NOT be counted as drops.
REQ-025 DONE SHALL be terminal until reset; in DONE, done=1 and trace_valid=0.
REQ-026 A simultaneous push and pop on a full FIFO SHALL accept the push, and the pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 Reset SHALL clear the FIFO, the FSM (to IDLE), the halt latch, instret, drop_cnt and the sequence number.
REQ-028 Output values under reset: hold=0, trace_valid=0, trace_data=0, overflow=0, done=0.
REQ-029 A reset asserted in the middle of a record SHALL abandon that record with no further trace words.

Configuration
REQ-030 Macro COMMIT_TRACE_CYCLE_EN: when defined, a free-running 32-bit cycle counter (cleared by reset) SHALL be captured per record and sent as a word immediately after inst, with header bit [23] forced to 1 and the sequence number reduced to 23 bits.
REQ-031 When COMMIT_TRACE_CYCLE_EN is not defined, no cycle counter SHALL exist and the record format SHALL be as in REQ-017/018.

Structure
REQ-032 Shared package commit_trace_pkg SHALL hold the packed record type (halt, flags, wa, pc, inst, wd, dmem_wa, dmem_wd, optional cycle), the header bit-position constants and the FSM state encoding.
REQ-033 The FIFO SHALL be a separate sub-module commit_trace_fifo (parameter DEPTH, push/pop/full/empty/count); serializer and counters stay in commit_tracer.

Verification
REQ-034 Case 1: one commit with pc=0x0, inst=0x00100093, reg_we=1, wa=1, wd=1, trace_ready=1 SHALL produce 4 words: 0x41000000, 0x0, 0x00100093, 0x1; instret SHALL read 1.
REQ-035 Case 2: one store with dmem_we=1, wa=0x1C00, wd=0xDEAD, as sequence #5, SHALL produce 5 words, with the header 0x20000005 followed by 0x1C00 and then 0xDEAD.
REQ-036 Case 3: with trace_ready=0 and DEPTH=8, 9 commits with hold ignored SHALL give overflow=1, drop_cnt=1, and hold=1 from the 7th push onward.
REQ-037 Case 4: trace_ready toggling 1/0 every cycle SHALL leave trace_data unchanged while ready=0 and emit no duplicated or lost words across 3 records.
REQ-038 Case 5: a halt record followed by 2 commits SHALL give done=1 after the halt record's last handshake, instret unchanged by the 2 extra commits, and drop_cnt=0.
REQ-039 Case 6: rst=0 in the middle of a record SHALL give trace_valid=0 the next cycle, and the first record after reset SHALL carry sequence number 0.
